// File: rtl/window3x3_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : window3x3_gen_if
//  Description : Column-in / window-out stream bundle for window3x3_gen.
//  Revision    : 1.0
// ============================================================================
interface window3x3_gen_if #(
    parameter int DATA_WIDTH = 14,
    parameter int COL_WIDTH  = 8
);
    logic [3*DATA_WIDTH-1:0] data_in;
    logic                    datain_valid;
    logic [9*DATA_WIDTH-1:0] window_out;
    logic                    dataout_valid;
    logic                    dataout_sol;
    logic                    dataout_eol;
    logic [COL_WIDTH-1:0]    col_idx;

    // Upstream side: presents aligned columns and observes windows.
    modport master (
        output data_in, datain_valid,
        input  window_out, dataout_valid, dataout_sol, dataout_eol, col_idx
    );

    // Window generator side.
    modport slave (
        input  data_in, datain_valid,
        output window_out, dataout_valid, dataout_sol, dataout_eol, col_idx
    );
endinterface
`default_nettype wire

// File: rtl/window3x3_gen.sv
`default_nettype none
// ============================================================================
//  Module      : window3x3_gen
//  Description : Builds a registered 3x3 neighbourhood from aligned 3-pixel
//                columns; windows never straddle a line boundary.
//  Revision    : 1.0
// ============================================================================
module window3x3_gen #(
    parameter int DATA_WIDTH  = 14,
    parameter int IMAGE_WIDTH = 240,
    parameter int COL_WIDTH   = 8
) (
    input  wire logic          clk,
    input  wire logic          arst,
    window3x3_gen_if.slave     bus
);
    localparam logic [COL_WIDTH-1:0] c_last  = COL_WIDTH'(IMAGE_WIDTH - 1);
    localparam logic [COL_WIDTH-1:0] c_first = COL_WIDTH'(2);

    logic [COL_WIDTH-1:0]         r_col_cnt;
    logic [2:0][DATA_WIDTH-1:0]   r_sh0;
    logic [2:0][DATA_WIDTH-1:0]   r_sh1;
    logic [2:0][DATA_WIDTH-1:0]   w_col;
    logic [9*DATA_WIDTH-1:0]      w_window;
    logic [9*DATA_WIDTH-1:0]      r_window;
    logic                         r_valid;
    logic                         r_sol;
    logic                         r_eol;
    logic [COL_WIDTH-1:0]         r_col_idx;

    assign w_col = bus.data_in;

    // Tap (r,c) sits at slice 3*r+c; column 0 is the oldest.
    generate
        for (genvar r = 0; r < 3; r++) begin : g_row
            assign w_window[(3*r+0)*DATA_WIDTH +: DATA_WIDTH] = r_sh1[r];
            assign w_window[(3*r+1)*DATA_WIDTH +: DATA_WIDTH] = r_sh0[r];
            assign w_window[(3*r+2)*DATA_WIDTH +: DATA_WIDTH] = w_col[r];
        end
    endgenerate

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_col_cnt <= '0;
            r_sh0     <= '0;
            r_sh1     <= '0;
            r_window  <= '0;
            r_valid   <= 1'b0;
            r_sol     <= 1'b0;
            r_eol     <= 1'b0;
            r_col_idx <= '0;
        end else begin
            r_valid <= 1'b0;
            r_sol   <= 1'b0;
            r_eol   <= 1'b0;
            if (bus.datain_valid) begin
                r_sh1     <= r_sh0;
                r_sh0     <= w_col;
                r_col_cnt <= (r_col_cnt == c_last) ? '0 : r_col_cnt + COL_WIDTH'(1);
                // Columns 0 and 1 only prime the shifters, flushing the previous line.
                if (r_col_cnt >= c_first) begin
                    r_window  <= w_window;
                    r_valid   <= 1'b1;
                    r_col_idx <= r_col_cnt - COL_WIDTH'(1);
                    r_sol     <= (r_col_cnt == c_first);
                    r_eol     <= (r_col_cnt == c_last);
                end
            end
        end
    end

    assign bus.window_out    = r_window;
    assign bus.dataout_valid = r_valid;
    assign bus.dataout_sol   = r_sol;
    assign bus.dataout_eol   = r_eol;
    assign bus.col_idx       = r_col_idx;
endmodule
`default_nettype wire

// File: tb/tb_window3x3_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_window3x3_gen
//  Description : Scoreboard bench for window3x3_gen (240-wide and 3-wide builds).
//  Revision    : 1.0
// ============================================================================
module tb_window3x3_gen;
    localparam int DW = 14;
    localparam int IW = 240;
    localparam int CW = 8;

    typedef struct packed {
        logic [9*DW-1:0] win;
        logic [CW-1:0]   col;
        logic            sol;
        logic            eol;
    } exp_t;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    window3x3_gen_if #(.DATA_WIDTH(DW), .COL_WIDTH(CW)) bus ();
    window3x3_gen_if #(.DATA_WIDTH(DW), .COL_WIDTH(CW)) bus3 ();

    window3x3_gen #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .COL_WIDTH(CW)) dut (
        .clk(clk), .arst(arst), .bus(bus));
    window3x3_gen #(.DATA_WIDTH(DW), .IMAGE_WIDTH(3), .COL_WIDTH(CW)) dut3 (
        .clk(clk), .arst(arst), .bus(bus3));

    exp_t q[$];
    exp_t q3[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   pulses   = 0;
    int   pulses3  = 0;
    int   cyc      = 0;
    int   last_eol_cyc = -100;
    int   gap_checks   = 0;
    bit   check_gap    = 1'b0;
    logic [9*DW-1:0] last_win;
    logic [CW-1:0]   last_col;

    task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int off, input int j, input int r);
        return DW'(j + 1000*r + off);
    endfunction

    // Expected window captured on the beat carrying column j.
    function automatic exp_t mk(input int off, input int j, input int iw);
        exp_t e;
        e.win = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                e.win[(3*r+c)*DW +: DW] = pix(off, j-2+c, r);
        e.col = CW'(j-1);
        e.sol = (j == 2);
        e.eol = (j == iw-1);
        return e;
    endfunction

    task automatic idle();
        bus.datain_valid  = 1'b0;
        bus3.datain_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send_col(input int off, input int j, input int gap_pct);
        while ($urandom_range(0, 99) < gap_pct) idle();
        bus.data_in      = {pix(off, j, 2), pix(off, j, 1), pix(off, j, 0)};
        bus.datain_valid = 1'b1;
        if (j >= 2) q.push_back(mk(off, j, IW));
        @(posedge clk); #1;
        bus.datain_valid = 1'b0;
    endtask

    task automatic send_line(input int off, input int gap_pct);
        for (int j = 0; j < IW; j++) send_col(off, j, gap_pct);
    endtask

    task automatic send3(input int off, input int j);
        bus3.data_in      = {pix(off, j, 2), pix(off, j, 1), pix(off, j, 0)};
        bus3.datain_valid = 1'b1;
        if (j == 2) q3.push_back(mk(off, j, 3));
        @(posedge clk); #1;
        bus3.datain_valid = 1'b0;
    endtask

    // Monitor for the 240-wide build.
    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (arst) begin
            chk("reset_window", bus.window_out, '0);
            chk("reset_flags", {bus.dataout_valid, bus.dataout_sol, bus.dataout_eol}, '0);
            chk("reset_col_idx", bus.col_idx, '0);
            last_win = '0;
            last_col = '0;
        end else if (bus.dataout_valid) begin
            pulses++;
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                chk("window", bus.window_out, e.win);
                chk("col_idx", bus.col_idx, e.col);
                chk("sol", bus.dataout_sol, e.sol);
                chk("eol", bus.dataout_eol, e.eol);
            end
            if (bus.dataout_sol && check_gap) begin
                gap_checks++;
                chk("eol_to_sol_gap", cyc - last_eol_cyc, 3);
            end
            if (bus.dataout_eol) last_eol_cyc = cyc;
            last_win = bus.window_out;
            last_col = bus.col_idx;
        end else begin
            chk("idle_window_hold", bus.window_out, last_win);
            chk("idle_col_hold", bus.col_idx, last_col);
            chk("idle_flags", {bus.dataout_sol, bus.dataout_eol}, '0);
        end
    end

    // Monitor for the 3-wide build.
    always @(negedge clk) begin : mon3
        exp_t e;
        if (!arst && bus3.dataout_valid) begin
            pulses3++;
            if (q3.size() == 0) begin
                chk("w3_unexpected_valid", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("w3_window", bus3.window_out, e.win);
                chk("w3_col_idx", bus3.col_idx, e.col);
                chk("w3_sol_eol", {bus3.dataout_sol, bus3.dataout_eol}, {e.sol, e.eol});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        arst              = 1'b1;
        bus.data_in       = '0;
        bus.datain_valid  = 1'b0;
        bus3.data_in      = '0;
        bus3.datain_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 arst = 1'b0;
        @(posedge clk); #1;

        // Single continuous line.
        send_line(0, 0);
        repeat (3) idle();
        chk("line1_pulses", pulses, 238);
        chk("line1_queue_empty", q.size(), 0);

        // Two back-to-back lines; gap measured at the second sol.
        pulses = 0;
        send_line(0, 0);
        check_gap = 1'b1;
        send_line(100, 0);
        repeat (3) idle();
        check_gap = 1'b0;
        chk("b2b_pulses", pulses, 476);
        chk("b2b_gap_checks", gap_checks, 1);
        chk("b2b_queue_empty", q.size(), 0);

        // Twelve lines with ~30% idle beats.
        pulses = 0;
        for (int k = 0; k < 12; k++) send_line(k*100, 30);
        repeat (3) idle();
        chk("gaps_pulses", pulses, 12*238);
        chk("gaps_queue_empty", q.size(), 0);

        // Asynchronous reset mid-line after column 120.
        pulses = 0;
        for (int j = 0; j <= 120; j++) send_col(300, j, 0);
        repeat (2) idle();
        chk("prereset_pulses", pulses, 119);
        chk("prereset_queue_empty", q.size(), 0);
        #3 arst = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 arst = 1'b0;
        @(posedge clk); #1;
        pulses = 0;
        send_line(5000, 0);
        repeat (3) idle();
        chk("postreset_pulses", pulses, 238);
        chk("postreset_queue_empty", q.size(), 0);

        // Three-column build: one window per line.
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 3; j++) send3(k*10, j);
        repeat (3) idle();
        chk("w3_pulses", pulses3, 4);
        chk("w3_queue_empty", q3.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
